// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core.
// Loads are answered combinationally from a word array. A youngest-first
// forwarding search over a small in-order write buffer keeps loads coherent.
// Stores are posted into that buffer and drained to the array at a throttled
// rate. When the buffer is full, the next store forces a drain, so the core
// never stalls and no store is lost.
module mips_data_mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int WBUF_DEPTH = 4,
  parameter int DRAIN_GAP  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   addr,
  input  logic [31:0]                   wdata,
  input  logic                          mem_read,
  input  logic                          mem_write,
  output logic [31:0]                   rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          wbuf_full,
  output logic                          busy,
  output logic                          misalign_err
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } drain_state_t;

  drain_state_t       state;
  logic [GAP_W-1:0]   gap;
  logic [PTR_W-1:0]   head;
  logic [CNT_W-1:0]   count;

  logic [ADDR_W-1:0]  buf_idx  [WBUF_DEPTH];
  logic [31:0]        buf_data [WBUF_DEPTH];
  logic [31:0]        mem      [2**ADDR_W];

  logic [ADDR_W-1:0]  idx;
  logic [PTR_W-1:0]   tail;
  logic               full_now;
  logic               push;
  logic               force_pop;
  logic               normal_pop;
  logic               pop;
  logic               misaligned;

  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic [PTR_W-1:0]   slot;

  // Address bits above the word index only alias into the array.
  logic               unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign idx        = addr[ADDR_W+1:2];
  // When the buffer is full, the low count bits are zero, so tail == head.
  // A forced pop then frees exactly the slot the new entry takes.
  assign tail       = head + count[PTR_W-1:0];
  assign full_now   = (count == CNT_W'(WBUF_DEPTH));
  assign push       = rst & mem_write;
  assign force_pop  = rst & full_now & mem_write;
  assign normal_pop = rst & (state == S_IDLE) & (count != '0);
  assign pop        = force_pop | normal_pop;
  assign misaligned = (mem_read | mem_write) & (addr[1:0] != 2'b00);

  assign wbuf_count = count;
  assign wbuf_full  = full_now;
  assign busy       = (count != '0);

  // Youngest matching buffer entry wins: scan oldest to youngest, last hit sticks.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (buf_idx[slot] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[slot];
      end
    end
  end

  assign rdata = !mem_read ? 32'd0 : (fwd_hit ? fwd_data : mem[idx]);

  // Drain FSM, buffer occupancy and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      gap          <= '0;
      head         <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
      if (pop) begin
        if (DRAIN_GAP == 0) begin
          state <= S_IDLE;
          gap   <= '0;
        end else begin
          state <= S_WAIT;
          gap   <= GAP_W'(DRAIN_GAP);
        end
      end else if (state == S_WAIT) begin
        if (gap <= GAP_W'(1)) begin
          state <= S_IDLE;
          gap   <= '0;
        end else begin
          gap <= gap - GAP_W'(1);
        end
      end
    end
  end

  // Retire the head entry into the word array; reset suppresses pop, so the array is never disturbed by it.
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[buf_idx[head]] <= buf_data[head];
    end
  end

  // Post a store at the tail; a same-edge forced pop has already read the old head value.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_idx[tail]  <= idx;
      buf_data[tail] <= wdata;
    end
  end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder.
// A queue-based reference model predicts every cycle's outputs. The driver
// pushes each prediction into a queue, and a negedge monitor pops and compares it.
module tb_mips_data_mem_responder;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] rdata;
  logic [$clog2(DEPTH):0] wbuf_count;
  logic        wbuf_full;
  logic        busy;
  logic        misalign_err;

  mips_data_mem_responder #(
    .ADDR_W    (AW),
    .WBUF_DEPTH(DEPTH),
    .DRAIN_GAP (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .rdata       (rdata),
    .wbuf_count  (wbuf_count),
    .wbuf_full   (wbuf_full),
    .busy        (busy),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
    int          count;
    bit          full;
    bit          busy;
    bit          mis;
  } exp_t;

  // Reference model: array image, pending-store queue, drain cooldown, sticky flag.
  logic [31:0] mem_m [1<<AW];
  ent_t        pend[$];
  int          cool = 0;
  bit          mis_m = 1'b0;

  exp_t        sbq[$];
  exp_t        me;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: one prediction per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      if (me.chk) begin
        check("rdata",        rdata,             me.rdata);
        check("wbuf_count",   32'(wbuf_count),   32'(me.count));
        check("wbuf_full",    32'(wbuf_full),    32'(me.full));
        check("busy",         32'(busy),         32'(me.busy));
        check("misalign_err", 32'(misalign_err), 32'(me.mis));
      end
    end
  end

  // Drive one cycle: predict outputs from the current model state, then apply the clock edge to the model.
  task automatic cycle(input bit r, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, input bit chk);
    exp_t e;
    int   ix;
    rst       = r;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    ix = int'((a >> 2) & ((32'd1 << AW) - 1));
    e.chk   = chk;
    e.rdata = 32'd0;
    if (rd) begin
      e.rdata = mem_m[ix];
      foreach (pend[k]) if (pend[k].idx == ix) e.rdata = pend[k].data;
    end
    e.count = pend.size();
    e.full  = (pend.size() == DEPTH);
    e.busy  = (pend.size() != 0);
    e.mis   = mis_m;
    sbq.push_back(e);
    @(posedge clk);
    if (!r) begin
      pend.delete();
      cool  = 0;
      mis_m = 1'b0;
    end else begin
      if ((rd || wr) && a[1:0] != 2'b00) mis_m = 1'b1;
      if (pend.size() > 0 && ((pend.size() == DEPTH && wr) || cool == 0)) begin
        ent_t h;
        h = pend.pop_front();
        mem_m[h.idx] = h.data;
        cool = GAP;
      end else if (cool > 0) begin
        cool--;
      end
      if (wr) pend.push_back('{ix, d});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'd0, 32'd0, 1);
  endtask

  task automatic load(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, a, 32'd0, 1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held two cycles with a store pending on the bus.
    cycle(0, 0, 1, 32'h40, 32'h1111_1111, 0);
    cycle(0, 0, 1, 32'h40, 32'h2222_2222, 1);

    // Fill every word with known random data; addresses carry random upper bits to exercise index wrap.
    for (int i = 0; i < (1 << AW); i++)
      cycle(1, 0, 1, (32'($urandom()) << (AW + 2)) | (32'(i) << 2), $urandom(), 1);
    idle(20);

    // Reset with a store buffered: discarded stores must not reach the array.
    cycle(1, 0, 1, 32'h40, 32'h0000_A5A5, 1);
    cycle(0, 0, 1, 32'h44, 32'h0000_1234, 1);
    cycle(0, 0, 1, 32'h44, 32'h0000_5678, 1);
    load(32'h40, 2);
    load(32'h44, 2);

    // Forwarding, then read back from the array.
    cycle(1, 0, 1, 32'h10, 32'hDEAD_BEEF, 1);
    load(32'h10, 1);
    idle(16);
    load(32'h10, 1);

    // Youngest of three same-word stores wins.
    cycle(1, 0, 1, 32'h20, 32'h1, 1);
    cycle(1, 0, 1, 32'h20, 32'h2, 1);
    cycle(1, 0, 1, 32'h20, 32'h3, 1);
    load(32'h20, 16);

    // Full pressure: eight back-to-back stores to distinct words.
    for (int i = 0; i < 8; i++) cycle(1, 0, 1, 32'(i * 4), 32'(i), 1);
    idle(20);
    for (int i = 0; i < 8; i++) load(32'(i * 4), 1);

    // Reset mid-drain.
    cycle(1, 0, 1, 32'h80, 32'hAAAA_0001, 1);
    cycle(1, 0, 1, 32'h84, 32'hAAAA_0002, 1);
    cycle(1, 0, 1, 32'h88, 32'hAAAA_0003, 1);
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    load(32'h80, 1);
    load(32'h84, 1);
    load(32'h88, 1);

    // Misaligned load with upper-bit wrap; the flag stays set.
    load(32'h0000_0402, 1);
    idle(4);
    load(32'h0, 1);

    // Same-cycle load and store: the load sees the pre-store value.
    cycle(1, 1, 1, 32'h30, 32'h5555_AAAA, 1);
    load(32'h30, 1);

    // Randomized traffic over a small hot window, with rare resets and misaligned accesses.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 31) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << (AW + 2));
      cycle(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, a, $urandom(), 1);
    end
    idle(20);
    for (int i = 0; i < 16; i++) load(32'h100 + 32'(i * 4), 1);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
